ame_equation_builder: RTL and testbench

Streaming accumulator that builds the 6x7 affine normal-equation system (A | B) for affine motion estimation, one gradient/residual sample per cycle. It sits directly upstream of the equation solver. Its `comp_data_o` / `comp_done_o` connect straight to the solver's matrix input and `comp_init_i`, and it uses the same row/column layout for 4- and 6-parameter modes. All arithmetic is exact two's-complement integer; there is no rounding.

---
 rtl/ame_equation_builder.sv | 182 ++++++++++++++++++
 tb/tb_ame_equation_builder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ame_equation_builder.sv
// Streaming accumulator for the 6x7 affine normal-equation system (A | B).
// S1 registers the coefficients, S2 the 27 unique products, S3 accumulates them.
module ame_equation_builder #(
  parameter int COMP_DATA_BITS = 64,
  parameter int GRAD_BITS      = 16,
  parameter int POS_BITS       = 7
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic                                   comp_init_i,
  input  logic                                   affine_param6_i,
  input  logic                                   samp_valid_i,
  output logic                                   samp_ready_o,
  input  logic                                   samp_last_i,
  input  logic signed [GRAD_BITS-1:0]            samp_gx_i,
  input  logic signed [GRAD_BITS-1:0]            samp_gy_i,
  input  logic        [POS_BITS-1:0]             samp_x_i,
  input  logic        [POS_BITS-1:0]             samp_y_i,
  input  logic signed [GRAD_BITS-1:0]            samp_err_i,
  output logic                                   comp_done_o,
  output logic        [14:0]                     comp_count_o,
  output logic        [5:0][6:0][COMP_DATA_BITS-1:0] comp_data_o
);

  localparam int C_BITS = GRAD_BITS + POS_BITS + 2;
  localparam int P_BITS = 2 * C_BITS;
  localparam int N_UP   = 21;
  localparam int N_ACC  = 27;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;

  // Upper-triangle (r <= c) element index into the packed product/accumulator arrays.
  function automatic int tri_idx(input int r, input int c);
    return (r * (11 - r)) / 2 + c;
  endfunction

  state_e state_q, state_d;
  logic   drain_q;
  logic   mode6_q;
  logic   accept;

  logic signed [C_BITS-1:0] gx_e, gy_e, x_e, y_e, err_e;
  logic signed [C_BITS-1:0] xgx, xgy, ygx, ygy;
  logic signed [C_BITS-1:0] c_d [6];
  logic signed [C_BITS-1:0] c_q [6];
  logic signed [C_BITS-1:0] err_q;
  logic signed [P_BITS-1:0] ce [6];
  logic signed [P_BITS-1:0] ee;
  logic signed [P_BITS-1:0] prod_q [N_ACC];
  logic [COMP_DATA_BITS-1:0] prod_ext [N_ACC];
  logic [COMP_DATA_BITS-1:0] acc_q [N_ACC];
  logic s1_vld_q, s2_vld_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == DRAIN) && (state_d == DRAIN);
    end
  end

  always_comb begin
    state_d = state_q;
    if (comp_init_i) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ACCUM:   if (accept && samp_last_i) state_d = DRAIN;
        DRAIN:   if (drain_q) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    samp_ready_o = (state_q == ACCUM);
    comp_done_o  = (state_q == DONE);
  end

  // An init in the same cycle aborts the block, so that sample is dropped.
  assign accept = samp_valid_i & samp_ready_o & ~comp_init_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode6_q      <= 1'b0;
      comp_count_o <= '0;
    end else if (comp_init_i) begin
      mode6_q      <= affine_param6_i;
      comp_count_o <= '0;
    end else if (accept) begin
      comp_count_o <= comp_count_o + 15'd1;
    end
  end

  // ---------------- S1: coefficients ----------------
  always_comb begin
    gx_e  = {{(C_BITS-GRAD_BITS){samp_gx_i[GRAD_BITS-1]}}, samp_gx_i};
    gy_e  = {{(C_BITS-GRAD_BITS){samp_gy_i[GRAD_BITS-1]}}, samp_gy_i};
    err_e = {{(C_BITS-GRAD_BITS){samp_err_i[GRAD_BITS-1]}}, samp_err_i};
    x_e   = {{(C_BITS-POS_BITS){1'b0}}, samp_x_i};
    y_e   = {{(C_BITS-POS_BITS){1'b0}}, samp_y_i};
    xgx   = x_e * gx_e;
    xgy   = x_e * gy_e;
    ygx   = y_e * gx_e;
    ygy   = y_e * gy_e;
    if (mode6_q) begin
      c_d[0] = gx_e;
      c_d[1] = xgx;
      c_d[2] = gy_e;
      c_d[3] = xgy;
      c_d[4] = ygx;
      c_d[5] = ygy;
    end else begin
      c_d[0] = '0;
      c_d[1] = '0;
      c_d[2] = gx_e;
      c_d[3] = xgx + ygy;
      c_d[4] = gy_e;
      c_d[5] = ygx - xgy;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int unsigned i = 0; i < 6; i++) c_q[i] <= c_d[i];
      err_q <= err_e;
    end
  end

  // ---------------- S2: products ----------------
  always_comb begin
    for (int unsigned i = 0; i < 6; i++)
      ce[i] = {{(P_BITS-C_BITS){c_q[i][C_BITS-1]}}, c_q[i]};
    ee = {{(P_BITS-C_BITS){err_q[C_BITS-1]}}, err_q};
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < 6; i++) begin
      for (int unsigned j = i; j < 6; j++)
        prod_q[tri_idx(i, j)] <= ce[i] * ce[j];
      prod_q[N_UP + i] <= ce[i] * ee;
    end
  end

  // ---------------- S3: accumulate ----------------
  always_comb begin
    for (int unsigned k = 0; k < N_ACC; k++)
      prod_ext[k] = {{(COMP_DATA_BITS-P_BITS){prod_q[k][P_BITS-1]}}, prod_q[k]};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      for (int unsigned k = 0; k < N_ACC; k++) acc_q[k] <= '0;
    end else if (comp_init_i) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      for (int unsigned k = 0; k < N_ACC; k++) acc_q[k] <= '0;
    end else begin
      s1_vld_q <= accept;
      s2_vld_q <= s1_vld_q;
      if (s2_vld_q)
        for (int unsigned k = 0; k < N_ACC; k++) acc_q[k] <= acc_q[k] + prod_ext[k];
    end
  end

  // Lower triangle mirrors the upper one; column 6 is B.
  for (genvar gi = 0; gi < 6; gi++) begin : g_row
    for (genvar gj = 0; gj < 7; gj++) begin : g_col
      localparam int K = (gj == 6) ? (N_UP + gi)
                       : ((gj >= gi) ? tri_idx(gi, gj) : tri_idx(gj, gi));
      assign comp_data_o[gi][gj] = acc_q[K];
    end
  end

endmodule

// File: tb/tb_ame_equation_builder.sv
// Directed self-checking bench for ame_equation_builder.
module tb_ame_equation_builder;

  logic                      clk_i = 1'b0;
  logic                      rst_n_i;
  logic                      comp_init_i;
  logic                      affine_param6_i;
  logic                      samp_valid_i;
  logic                      samp_ready_o;
  logic                      samp_last_i;
  logic signed [15:0]        samp_gx_i, samp_gy_i, samp_err_i;
  logic        [6:0]         samp_x_i, samp_y_i;
  logic                      comp_done_o;
  logic        [14:0]        comp_count_o;
  logic        [5:0][6:0][63:0] comp_data_o;

  int     errors = 0;
  int     checks = 0;
  int     done_seen = 0;
  int     d0;
  longint mc [6];
  longint me, mn;

  ame_equation_builder #(.COMP_DATA_BITS(64), .GRAD_BITS(16), .POS_BITS(7)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .comp_init_i(comp_init_i),
    .affine_param6_i(affine_param6_i), .samp_valid_i(samp_valid_i),
    .samp_ready_o(samp_ready_o), .samp_last_i(samp_last_i),
    .samp_gx_i(samp_gx_i), .samp_gy_i(samp_gy_i), .samp_x_i(samp_x_i),
    .samp_y_i(samp_y_i), .samp_err_i(samp_err_i), .comp_done_o(comp_done_o),
    .comp_count_o(comp_count_o), .comp_data_o(comp_data_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (comp_done_o) done_seen++;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic init_blk(input logic m6);
    comp_init_i     = 1'b1;
    affine_param6_i = m6;
    tick();
    comp_init_i     = 1'b0;
    affine_param6_i = ~m6;
  endtask

  task automatic send(input int gx, input int gy, input int x, input int y, input int err, input logic last);
    samp_valid_i = 1'b1;
    samp_last_i  = last;
    samp_gx_i    = gx[15:0];
    samp_gy_i    = gy[15:0];
    samp_x_i     = x[6:0];
    samp_y_i     = y[6:0];
    samp_err_i   = err[15:0];
    tick();
    samp_valid_i = 1'b0;
    samp_last_i  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int cyc = 1;
    while (!comp_done_o && cyc < 40) begin
      tick();
      cyc++;
    end
    chk(tag, cyc, exp_lat);
  endtask

  task automatic set_model(input bit m6, input longint gx, input longint gy, input longint x,
                           input longint y, input longint err, input longint n);
    if (m6) mc = '{gx, x*gx, gy, x*gy, y*gx, y*gy};
    else    mc = '{0, 0, gx, x*gx + y*gy, gy, y*gx - x*gy};
    me = err;
    mn = n;
  endtask

  task automatic check_matrix(input string tag);
    longint exp;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 7; j++) begin
        exp = (j == 6) ? mn * mc[i] * me : mn * mc[i] * mc[j];
        chk($sformatf("%s_A%0d%0d", tag, i, j), comp_data_o[i][j], exp);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    logic nz = 1'b0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 7; j++)
        nz |= (comp_data_o[i][j] != 64'd0);
    chk(tag, nz, 0);
  endtask

  initial begin
    rst_n_i = 1'b0; comp_init_i = 1'b0; affine_param6_i = 1'b0;
    samp_valid_i = 1'b0; samp_last_i = 1'b0;
    samp_gx_i = '0; samp_gy_i = '0; samp_x_i = '0; samp_y_i = '0; samp_err_i = '0;
    repeat (3) tick();
    chk("rst_ready", samp_ready_o, 0);
    chk("rst_done", comp_done_o, 0);
    chk("rst_count", comp_count_o, 0);
    check_zero("rst_data");

    // Valid while idle is ignored.
    rst_n_i = 1'b1;
    samp_valid_i = 1'b1; samp_last_i = 1'b1; samp_gx_i = 16'sd5;
    repeat (3) tick();
    chk("idle_ready", samp_ready_o, 0);
    chk("idle_count", comp_count_o, 0);
    chk("idle_done", comp_done_o, 0);
    samp_valid_i = 1'b0; samp_last_i = 1'b0;

    // 6-param single sample.
    init_blk(1'b1);
    chk("t1_ready", samp_ready_o, 1);
    check_zero("t1_init_zero");
    send(3, -2, 4, 5, 7, 1'b1);
    chk("t1_ready_L1", samp_ready_o, 0);
    chk("t1_done_L1", comp_done_o, 0);
    wait_done("t1_latency", 3);
    chk("t1_A00", comp_data_o[0][0], 9);
    chk("t1_A01", comp_data_o[0][1], 36);
    chk("t1_A10", comp_data_o[1][0], 36);
    chk("t1_A55", comp_data_o[5][5], 100);
    chk("t1_A06", comp_data_o[0][6], 21);
    chk("t1_A56", comp_data_o[5][6], -70);
    chk("t1_count", comp_count_o, 1);
    set_model(1'b1, 3, -2, 4, 5, 7, 1);
    check_matrix("t1");
    tick();
    chk("t1_done_L4", comp_done_o, 0);
    chk("t1_ready_L4", samp_ready_o, 0);
    chk("t1_hold_A00", comp_data_o[0][0], 9);

    // 4-param single sample.
    init_blk(1'b0);
    send(3, -2, 4, 5, 7, 1'b1);
    wait_done("t2_latency", 3);
    chk("t2_A22", comp_data_o[2][2], 9);
    chk("t2_A33", comp_data_o[3][3], 4);
    chk("t2_A35", comp_data_o[3][5], 46);
    chk("t2_A53", comp_data_o[5][3], 46);
    chk("t2_A56", comp_data_o[5][6], 161);
    set_model(1'b0, 3, -2, 4, 5, 7, 1);
    check_matrix("t2");

    // Init while in DONE: 64 samples with gaps and stray last-without-valid.
    chk("t3_in_done", comp_done_o, 1);
    init_blk(1'b1);
    chk("t3_ready", samp_ready_o, 1);
    for (int n = 0; n < 64; n++) begin
      int gaps = $urandom_range(0, 2);
      samp_valid_i = 1'b0;
      samp_last_i  = 1'b1;
      repeat (gaps) tick();
      send(1, 1, 0, 0, -1, n == 63);
    end
    wait_done("t3_latency", 3);
    chk("t3_A00", comp_data_o[0][0], 64);
    chk("t3_A02", comp_data_o[0][2], 64);
    chk("t3_A22", comp_data_o[2][2], 64);
    chk("t3_A06", comp_data_o[0][6], -64);
    chk("t3_count", comp_count_o, 64);
    set_model(1'b1, 1, 1, 0, 0, -1, 64);
    check_matrix("t3");

    // Extreme values, full 16384-sample block.
    init_blk(1'b1);
    for (int n = 0; n < 16384; n++) send(-32768, -32768, 127, 127, 32767, n == 16383);
    wait_done("t4_latency", 3);
    chk("t4_count", comp_count_o, 15'h4000);
    chk("t4_A00", comp_data_o[0][0], 64'h0000_1000_0000_0000);
    set_model(1'b1, -32768, -32768, 127, 127, 32767, 16384);
    check_matrix("t4");

    // Abort after 10 samples with data still in flight.
    init_blk(1'b1);
    d0 = done_seen;
    for (int n = 0; n < 10; n++) send(5, 3, 2, 1, 4, 1'b0);
    init_blk(1'b1);
    check_zero("t5_abort_zero");
    chk("t5_abort_count", comp_count_o, 0);
    send(1, 0, 0, 0, 1, 1'b1);
    wait_done("t5_latency", 3);
    tick();
    chk("t5_done_pulses", done_seen - d0, 1);
    chk("t5_count", comp_count_o, 1);
    set_model(1'b1, 1, 0, 0, 0, 1, 1);
    check_matrix("t5");

    // Asynchronous reset mid-block.
    init_blk(1'b1);
    send(2, 2, 2, 2, 2, 1'b0);
    send(2, 2, 2, 2, 2, 1'b0);
    samp_valid_i = 1'b1;
    samp_last_i  = 1'b0;
    repeat (3) tick();
    #2 rst_n_i = 1'b0;
    #1;
    chk("t6_rst_ready", samp_ready_o, 0);
    chk("t6_rst_done", comp_done_o, 0);
    chk("t6_rst_count", comp_count_o, 0);
    check_zero("t6_rst_data");
    tick();
    rst_n_i = 1'b1;
    samp_valid_i = 1'b1; samp_last_i = 1'b1;
    samp_gx_i = 16'sd1; samp_gy_i = '0; samp_x_i = '0; samp_y_i = '0; samp_err_i = 16'sd1;
    repeat (3) tick();
    chk("t6_post_ready", samp_ready_o, 0);
    chk("t6_post_count", comp_count_o, 0);
    check_zero("t6_post_data");
    init_blk(1'b1);
    send(1, 0, 0, 0, 1, 1'b1);
    wait_done("t6_latency", 3);
    chk("t6_count", comp_count_o, 1);
    set_model(1'b1, 1, 0, 0, 0, 1, 1);
    check_matrix("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
